// File: rtl/sb_tx_pkg.sv
// Shared types and constants for the sideband TX serializer.
// The header phase carries header parity (CP) and payload parity (DP) in its top two bits.
package sb_tx_pkg;

    localparam int         SB_HDR_W       = 62;
    localparam int         SB_PHASE_W     = 64;
    localparam int         CP_BIT         = 62;
    localparam int         DP_BIT         = 63;
    localparam logic [4:0] SB_DATA_OPCODE = 5'b11011;

    typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

    typedef struct packed {
        logic                  has_data;
        logic [SB_PHASE_W-1:0] data;
        logic [SB_HDR_W-1:0]   header;
    } sb_entry_t;

    function automatic logic [SB_PHASE_W-1:0] hdr_phase(input sb_entry_t e);
        logic [SB_PHASE_W-1:0] p;
        p         = {2'b00, e.header};
        p[CP_BIT] = ^e.header;
        p[DP_BIT] = e.has_data & (^e.data);
        return p;
    endfunction

endpackage

// File: rtl/sb_tx_packet_serializer_fifo.sv
// Packet entry FIFO for the sideband serializer; full/empty come from the registered count.
// A flush clears the pointers and discards any push in the same cycle.
module sb_tx_pkt_fifo
    import sb_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  sb_entry_t push_entry,
    input  logic      pop,
    input  logic      flush,
    output sb_entry_t head,
    output logic      full,
    output logic      empty,
    output logic      overflow
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          do_push, do_pop;
    sb_entry_t     mem [DEPTH];

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // Sticky: only an async reset clears it, never a flush.
            if (push && full) overflow <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
            end
        end
    end

endmodule

// File: rtl/sb_tx_packet_serializer.sv
// Sideband TX serializer: buffers encoder packets, shifts header/data phases LSB-first
// with a gated clock enable, and enforces a fixed idle gap after every packet.
module sb_tx_packet_serializer
    import sb_tx_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         GAP_UI      = 32,
    parameter logic [4:0] DATA_OPCODE = SB_DATA_OPCODE
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [SB_HDR_W-1:0]   i_header,
    input  logic                  i_header_valid,
    input  logic [SB_PHASE_W-1:0] i_data,
    input  logic                  i_flush,
    output logic                  o_sb_data,
    output logic                  o_sb_clk_en,
    output logic                  o_fifo_full,
    output logic                  o_busy,
    output logic                  o_pkt_done,
    output logic                  o_overflow
);

    localparam int               GAP_W    = (GAP_UI > 1) ? $clog2(GAP_UI) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_UI - 1);

    sb_entry_t             push_entry, head;
    logic                  fifo_empty, pop, gap_last;
    state_t                state;
    logic [SB_PHASE_W-1:0] shreg, data_q;
    logic                  has_data_q;
    logic [5:0]            bit_cnt;
    logic [GAP_W-1:0]      gap_cnt;

    assign push_entry.has_data = (i_header[4:0] == DATA_OPCODE);
    assign push_entry.data     = i_data;
    assign push_entry.header   = i_header;

    assign gap_last = (gap_cnt == GAP_LAST);
    // The last gap cycle pops directly so the next packet starts without an IDLE cycle.
    assign pop      = !i_flush && !fifo_empty &&
                      ((state == IDLE) || ((state == GAP) && gap_last));
    assign o_busy   = (state != IDLE) || !fifo_empty;

    sb_tx_pkt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .push       (i_header_valid),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (i_flush),
        .head       (head),
        .full       (o_fifo_full),
        .empty      (fifo_empty),
        .overflow   (o_overflow)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            data_q      <= '0;
            has_data_q  <= 1'b0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            o_sb_data   <= 1'b0;
            o_sb_clk_en <= 1'b0;
            o_pkt_done  <= 1'b0;
        end else begin
            o_sb_data   <= 1'b0;
            o_sb_clk_en <= 1'b0;
            o_pkt_done  <= 1'b0;
            if (i_flush) begin
                state   <= IDLE;
                bit_cnt <= '0;
                gap_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            shreg      <= hdr_phase(head);
                            data_q     <= head.data;
                            has_data_q <= head.has_data;
                            bit_cnt    <= '0;
                            state      <= HDR;
                        end
                    end
                    HDR, DATA: begin
                        o_sb_data   <= shreg[0];
                        o_sb_clk_en <= 1'b1;
                        shreg       <= shreg >> 1;
                        bit_cnt     <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd63) begin
                            if ((state == HDR) && has_data_q) begin
                                shreg <= data_q;
                                state <= DATA;
                            end else begin
                                o_pkt_done <= 1'b1;
                                gap_cnt    <= '0;
                                state      <= GAP;
                            end
                        end
                    end
                    GAP: begin
                        gap_cnt <= gap_cnt + 1'b1;
                        if (gap_last) begin
                            gap_cnt <= '0;
                            if (pop) begin
                                shreg      <= hdr_phase(head);
                                data_q     <= head.data;
                                has_data_q <= head.has_data;
                                bit_cnt    <= '0;
                                state      <= HDR;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sb_tx_packet_serializer.sv
// Bench for sb_tx_packet_serializer: directed vector table, corner-case sequences and a
// randomized run checked against a packet-level timing/content model.
module tb_sb_tx_packet_serializer;

    localparam int FIFO_DEPTH = 4;
    localparam int GAP_UI     = 32;

    logic        i_clk, i_rst_n, i_header_valid, i_flush;
    logic [61:0] i_header;
    logic [63:0] i_data;
    logic        o_sb_data, o_sb_clk_en, o_fifo_full, o_busy, o_pkt_done, o_overflow;

    sb_tx_packet_serializer #(.FIFO_DEPTH(FIFO_DEPTH), .GAP_UI(GAP_UI), .DATA_OPCODE(5'b11011)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_header(i_header), .i_header_valid(i_header_valid),
        .i_data(i_data), .i_flush(i_flush), .o_sb_data(o_sb_data), .o_sb_clk_en(o_sb_clk_en),
        .o_fifo_full(o_fifo_full), .o_busy(o_busy), .o_pkt_done(o_pkt_done), .o_overflow(o_overflow)
    );

    typedef struct {
        int           start;
        int           len;
        logic [127:0] bits;
        int           done_at;
        int           done_cnt;
    } pkt_t;

    typedef struct {
        logic [61:0]  hdr;
        logic [63:0]  data;
        int           len;
        logic [127:0] bits;
    } vec_t;

    int   checks = 0, failures = 0, glitches = 0;
    int   cyc = 0, last_push = 0, last_end = -1000;
    bit   model_ovf = 0;
    pkt_t obs_q[$], exp_q[$];
    int   acc_push[$], acc_pop[$];
    vec_t vecs[7];

    initial begin
        i_clk = 0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    // Monitor: each clocked bit is sampled mid-cycle; a packet closes when the enable drops.
    initial begin
        pkt_t cur;
        bit   in_pkt;
        in_pkt = 0;
        cur    = '{0, 0, '0, -1, 0};
        forever begin
            @(negedge i_clk);
            if (o_sb_clk_en) begin
                if (!in_pkt) begin
                    in_pkt = 1;
                    cur    = '{cyc, 0, '0, -1, 0};
                end
                if (cur.len < 128) cur.bits[cur.len] = o_sb_data;
                if (o_pkt_done) begin
                    cur.done_at = cur.len;
                    cur.done_cnt++;
                end
                cur.len++;
            end else begin
                if (o_sb_data || o_pkt_done) glitches++;
                if (in_pkt) begin
                    obs_q.push_back(cur);
                    in_pkt = 0;
                end
            end
        end
    end

    // Reference: a packet starts GAP_UI+1 cycles after the previous one's last bit, or two
    // cycles after its push, whichever is later; pushes are dropped while the queue is full.
    function automatic void model_push(int t, logic [61:0] h, logic [63:0] d);
        int   occ;
        bit   has;
        pkt_t p;
        occ = 0;
        foreach (acc_push[i]) if (acc_push[i] < t && acc_pop[i] >= t) occ++;
        if (occ >= FIFO_DEPTH) begin
            model_ovf = 1;
            return;
        end
        has        = (h[4:0] == 5'b11011);
        p.len      = has ? 128 : 64;
        p.bits     = {has ? d : 64'h0, has ? ^d : 1'b0, ^h, h};
        p.start    = (last_end + GAP_UI + 1 > t + 2) ? last_end + GAP_UI + 1 : t + 2;
        p.done_at  = p.len - 1;
        p.done_cnt = 1;
        last_end   = p.start + p.len - 1;
        acc_push.push_back(t);
        acc_pop.push_back(p.start - 1);
        exp_q.push_back(p);
    endfunction

    function automatic void model_flush();
        acc_push.delete();
        acc_pop.delete();
        exp_q.delete();
        last_end = -1000;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cycle(bit v, logic [61:0] h, logic [63:0] d);
        @(negedge i_clk);
        i_header_valid = v;
        i_header       = h;
        i_data         = d;
        if (v) begin
            last_push = cyc + 1;
            model_push(cyc + 1, h, d);
        end
    endtask

    task automatic wait_idle(string name);
        int n;
        n = 0;
        while (o_busy && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        if (o_busy) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: o_busy still 1 after %0d cycles, expected 0", name, n);
        end
        repeat (3) @(negedge i_clk);
    endtask

    task automatic compare_all(string tag);
        wait_idle(tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_pkt%0d_start", tag, i), obs_q[i].start, exp_q[i].start);
            chk($sformatf("%s_pkt%0d_bits", tag, i), obs_q[i].bits, exp_q[i].bits);
            chk($sformatf("%s_pkt%0d_len_done", tag, i),
                {32'(obs_q[i].len), 32'(obs_q[i].done_at), 32'(obs_q[i].done_cnt)},
                {32'(exp_q[i].len), 32'(exp_q[i].done_at), 32'(exp_q[i].done_cnt)});
        end
        chk({tag, "_glitch"}, glitches, 0);
        glitches = 0;
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int s, p, burst;

        vecs[0] = '{62'h12, 64'h0, 64, 128'h12};
        vecs[1] = '{62'h1B, 64'h1, 128, {64'h1, 64'h8000_0000_0000_001B}};
        vecs[2] = '{62'h1, 64'hFFFF, 64, 128'h4000_0000_0000_0001};
        vecs[3] = '{62'h3FFF_FFFF_FFFF_FFFF, 64'h5, 64, 128'h3FFF_FFFF_FFFF_FFFF};
        vecs[4] = '{62'h2000_0000_0000_001B, 64'h3, 128, {64'h3, 64'h6000_0000_0000_001B}};
        vecs[5] = '{62'h1B, 64'h8000_0000_0000_0001, 128, {64'h8000_0000_0000_0001, 64'h1B}};
        vecs[6] = '{62'h3B, 64'h7, 128, {64'h7, 64'hC000_0000_0000_003B}};

        i_rst_n = 0; i_header_valid = 0; i_flush = 0; i_header = '0; i_data = '0;
        repeat (3) @(negedge i_clk);
        chk("reset_outputs", {o_sb_data, o_sb_clk_en, o_fifo_full, o_busy, o_pkt_done, o_overflow}, 6'b0);
        i_rst_n = 1;
        repeat (2) @(negedge i_clk);

        // Directed vectors, one packet at a time.
        for (int i = 0; i < 7; i++) begin
            drive_cycle(1, vecs[i].hdr, vecs[i].data);
            p = last_push;
            drive_cycle(0, '0, '0);
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_count", i), obs_q.size(), 1);
            if (obs_q.size() > 0) begin
                chk($sformatf("vec%0d_bits", i), obs_q[0].bits, vecs[i].bits);
                chk($sformatf("vec%0d_len_done", i), {32'(obs_q[0].len), 32'(obs_q[0].done_at)},
                    {32'(vecs[i].len), 32'(vecs[i].len - 1)});
                chk($sformatf("vec%0d_latency", i), obs_q[0].start, p + 2);
            end
            obs_q.delete();
            exp_q.delete();
        end

        // Back-to-back control packets.
        drive_cycle(1, 62'h12, '0);
        drive_cycle(1, 62'h0A, '0);
        drive_cycle(0, '0, '0);
        wait_idle("b2b");
        if (obs_q.size() >= 2) chk("b2b_spacing", obs_q[1].start - (obs_q[0].start + 63), 33);
        compare_all("b2b");

        // Overflow: six consecutive pushes into a depth-4 FIFO.
        for (int i = 0; i < 6; i++) drive_cycle(1, 62'h100 + 62'(i), '0);
        drive_cycle(0, '0, '0);
        chk("ovf_flag_full", {o_overflow, o_fifo_full, model_ovf}, 3'b111);
        compare_all("ovf");
        chk("ovf_sticky", o_overflow, 1'b1);

        // Flush at header bit 20 with two entries queued, plus a push in the flush cycle.
        for (int i = 0; i < 3; i++) drive_cycle(1, 62'h21 + 62'(i), '0);
        s = exp_q[0].start;
        drive_cycle(0, '0, '0);
        while (cyc < s + 20) @(negedge i_clk);
        i_flush = 1; i_header_valid = 1; i_header = 62'h1B; i_data = 64'h1;
        @(negedge i_clk);
        i_flush = 0; i_header_valid = 0;
        chk("flush_outputs", {o_sb_clk_en, o_sb_data, o_busy, o_fifo_full, o_overflow}, 5'b00001);
        repeat (200) @(negedge i_clk);
        chk("flush_truncated", {32'(obs_q.size()), (obs_q.size() > 0) ? 32'(obs_q[0].len) : 32'd0,
            (obs_q.size() > 0) ? 32'(obs_q[0].done_cnt) : 32'd9}, {32'd1, 32'd21, 32'd0});
        obs_q.delete();
        model_flush();
        drive_cycle(1, 62'h33, '0);
        drive_cycle(0, '0, '0);
        compare_all("post_flush");

        // Async reset at data bit 10 with the overflow flag set.
        drive_cycle(1, 62'h1B, 64'hDEAD_BEEF_0123_4567);
        for (int i = 0; i < 5; i++) drive_cycle(1, 62'h200 + 62'(i), '0);
        s = exp_q[0].start;
        drive_cycle(0, '0, '0);
        while (cyc < s + 74) @(negedge i_clk);
        chk("pre_reset_ovf", o_overflow, 1'b1);
        #2 i_rst_n = 0;
        #1 chk("async_reset_outputs", {o_sb_data, o_sb_clk_en, o_fifo_full, o_busy, o_pkt_done, o_overflow}, 6'b0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1;
        chk("reset_truncated", {32'(obs_q.size()), (obs_q.size() > 0) ? 32'(obs_q[0].len) : 32'd0},
            {32'd1, 32'd75});
        obs_q.delete();
        model_flush();
        model_ovf = 0;
        @(negedge i_clk);
        chk("post_reset_empty", {o_busy, o_fifo_full, o_overflow}, 3'b000);
        drive_cycle(1, 62'h12, '0);
        drive_cycle(0, '0, '0);
        compare_all("post_reset");

        // Randomized traffic with occasional bursts.
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            bit          v;
            logic [61:0] h;
            logic [63:0] d;
            v = (burst > 0) || ($urandom_range(0, 59) == 0);
            if (burst > 0) burst--;
            else if (v && $urandom_range(0, 3) == 0) burst = $urandom_range(1, 5);
            h = 62'({$urandom(), $urandom()});
            if ($urandom_range(0, 1) == 1) h[4:0] = 5'b11011;
            d = {$urandom(), $urandom()};
            drive_cycle(v, h, d);
        end
        drive_cycle(0, '0, '0);
        compare_all("rand");
        chk("rand_overflow", o_overflow, model_ovf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sb_tx_packet_serializer.md
Name: sb_tx_packet_serializer

Overview:
Sideband TX stage directly downstream of the sideband header encoder. It buffers 62-bit headers, and 64-bit payloads for data opcodes, then appends parity to form 64-bit phases. It shifts each phase out LSB-first on the sideband data line with a gated-clock enable and enforces the inter-packet idle gap. This lets the encoder issue one-cycle header pulses back-to-back without stalling.

Parameters:
FIFO_DEPTH, 4, packet entries buffered (power of 2, >=2)
GAP_UI, 32, idle cycles (data low, clock gated) after every packet
DATA_OPCODE, 5'b11011, header[4:0] value that marks a packet carrying a 64-bit payload

Ports:
i_clk  in  1  sideband serializer clock, one UI per cycle
i_rst_n  in  1  async active-low reset
i_header  in  62  header from encoder
i_header_valid  in  1  one-cycle push strobe
i_data  in  64  payload, sampled with i_header_valid
i_flush  in  1  sync abort: empty FIFO, stop shifting
o_sb_data  out  1  serial sideband data
o_sb_clk_en  out  1  forwarded-clock gate, high only while a bit is driven
o_fifo_full  out  1  FIFO holds FIFO_DEPTH entries
o_busy  out  1  FSM not IDLE or FIFO non-empty
o_pkt_done  out  1  one-cycle pulse on the last bit of each packet
o_overflow  out  1  sticky: push dropped while full

Behaviour:
- Reset values: all outputs 0. FSM is IDLE, FIFO is empty, counters are 0.
- Push: on i_header_valid with !o_fifo_full, store {has_data, i_data, i_header}. has_data = (i_header[4:0]==DATA_OPCODE). A push while full is dropped and sets o_overflow; a pop in the same cycle does not rescue it, because full comes from the registered count.
- Phase format: bits[61:0] are the header. bit62 = CP = ^header[61:0]. bit63 = DP = ^data when has_data, else 0. The data phase is data[63:0] unmodified.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop, load the shift register with the header phase and go to HDR.
  - HDR: drive shreg[0], o_sb_clk_en=1, shift right, count 0..63. At count 63: if has_data, load the data phase and go to DATA; otherwise go to GAP.
  - DATA: same as HDR. At count 63, go to GAP. There is no gap between the header and data phases.
  - GAP: o_sb_data=0, o_sb_clk_en=0 for exactly GAP_UI cycles. On the final gap cycle: if the FIFO is non-empty, pop, load and go to HDR with no IDLE cycle; otherwise go to IDLE.
- Latency: with the FIFO empty and FSM in IDLE, push at edge N → pop/load at edge N+1 → bit0 visible after edge N+2, so 2 cycles.
- o_pkt_done asserts during the last bit of the packet: header bit 63 if no data, else data bit 63.
- Packet spacing: the last bit of packet k is followed by exactly GAP_UI low/gated cycles, then bit0 of packet k+1.
- o_sb_data and o_sb_clk_en are registered and glitch-free; o_sb_clk_en is 0 in IDLE and GAP.
- Counters: bit counter 6 bits, wrapping naturally at 63. Gap counter is $clog2(GAP_UI) bits.
- i_flush: on the next edge the FIFO pointers are cleared, the FSM goes to IDLE, and outputs drop to 0. o_overflow is not cleared.
  - A push in the same cycle as flush is discarded.
  - A flush mid-packet truncates the packet with no gap.
- Async reset mid-packet: everything returns to reset values immediately. o_overflow clears only on reset.

Decomposition:
- Package sb_tx_pkg:
  - state enum {IDLE, HDR, DATA, GAP}
  - SB_HDR_W=62, SB_PHASE_W=64
  - DATA_OPCODE default, CP_BIT=62, DP_BIT=63
  - entry struct {has_data, data, header}
- Sub-module sb_tx_pkt_fifo: synchronous FIFO, FIFO_DEPTH × 127 bits, with full/empty/flush and overflow flag.
- The serializer FSM lives in the top module.

Test Plan:
- Single control packet: i_header=62'h12 (opcode 10010), i_data=0 → 2 cycles later, 64 clocked bits LSB-first: 0,1,0,0,1 then zeros, bit62=0 (CP), bit63=0. o_pkt_done on bit 63, then 32 gated-low cycles, then o_busy=0.
- Data packet: header opcode 11011 (rest 0), i_data=64'h1 → 128 contiguous clocked bits. Header bit62=CP=0 (four ones), bit63=DP=1. Data phase bit64=1, rest 0. o_pkt_done on bit 127 only.
- Back-to-back: push two control headers on consecutive cycles → packet 2 bit0 appears exactly 33 cycles after packet 1 bit63, with no IDLE cycle between.
- Overflow: FIFO_DEPTH=4, push 6 headers on consecutive cycles → the first 5 are accepted (one pops on the second edge), the 6th is dropped. o_overflow=1 and stays high; exactly 5 packets are transmitted.
- Flush mid-packet: assert i_flush at header bit 20 with 2 entries queued → next cycle o_sb_clk_en=0, o_busy=0, no further bits. A new push afterward transmits normally.
- Reset mid-data-phase: deassert i_rst_n at data bit 10 → outputs 0 immediately and o_overflow cleared. After release, the FIFO is empty and a new push starts 2 cycles later.
